// File: rtl/l1_stream_out_pkg.sv
// Shared constants, bank encodings and FSM state type for the layer-1 readout stage.
package l1_stream_out_pkg;
    localparam int MAP_W = 32;
    localparam int MAP_H = 32;
    localparam int DW    = 20;
    localparam int AW    = 12;

    localparam logic [2:0] CSEL_L0 = 3'b001;
    localparam logic [2:0] CSEL_L1 = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/l1_stream_out_fifo.sv
// Synchronous DEPTH-entry FIFO; storage is not reset, pointers and count are.
module l1_fifo #(
    parameter int W     = 21,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/l1_stream_out.sv
// Reads the 32x32 layer-1 map from feature memory in raster order, streams it
// through a small FIFO on valid/ready and reports the frame maximum and its index.
module l1_stream_out #(
    parameter int             MAP_W     = l1_stream_out_pkg::MAP_W,
    parameter int             MAP_H     = l1_stream_out_pkg::MAP_H,
    parameter int             DW        = l1_stream_out_pkg::DW,
    parameter int             AW        = l1_stream_out_pkg::AW,
    parameter logic [AW-1:0]  BASE_ADDR = '0,
    parameter logic [2:0]     CSEL_L1   = l1_stream_out_pkg::CSEL_L1,
    parameter int             DEPTH     = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          crd,
    output logic [AW-1:0] caddr_rd,
    output logic [2:0]    csel,
    input  logic [DW-1:0] cdata_rd,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [DW-1:0] o_data,
    output logic          o_last,
    output logic [DW-1:0] max_val,
    output logic [9:0]    max_idx
);
    import l1_stream_out_pkg::*;

    localparam int            N        = MAP_W * MAP_H;
    localparam int            IW       = 10;
    localparam int            CW       = $clog2(DEPTH) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    // Handshake: a word moves downstream on every rising edge where o_valid
    // and o_ready are both high; o_valid/o_data/o_last hold while stalled.

    state_t        state;
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] cap_idx;
    logic          outstanding;
    logic [DW-1:0] run_max;
    logic [IW-1:0] run_idx;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [DW:0]   fifo_wdata;
    logic [DW:0]   fifo_rdata;
    logic [CW:0]   inflight;
    logic          can_issue;
    logic          issue;

    // Words already buffered plus the one in flight must fit in the FIFO.
    assign inflight  = {1'b0, fifo_count} + {{CW{1'b0}}, outstanding};
    assign can_issue = (inflight < (CW+1)'(DEPTH)) && !fifo_full;
    assign issue     = ((state == ST_IDLE && start) || state == ST_FETCH) && can_issue;

    assign fifo_push  = outstanding;
    assign fifo_wdata = {(cap_idx == LAST_IDX), cdata_rd};
    assign fifo_pop   = o_valid && o_ready;

    assign o_valid = !fifo_empty;
    assign o_data  = fifo_empty ? '0 : fifo_rdata[DW-1:0];
    assign o_last  = !fifo_empty && fifo_rdata[DW];

    l1_fifo #(
        .W     (DW + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            crd         <= 1'b0;
            caddr_rd    <= '0;
            csel        <= '0;
            rd_idx      <= '0;
            cap_idx     <= '0;
            outstanding <= 1'b0;
            run_max     <= '0;
            run_idx     <= '0;
            max_val     <= '0;
            max_idx     <= '0;
        end else begin
            done        <= 1'b0;
            crd         <= issue;
            outstanding <= issue;

            if (issue) begin
                caddr_rd <= BASE_ADDR + AW'(rd_idx);
                if (rd_idx != LAST_IDX) begin
                    rd_idx <= rd_idx + 1'b1;
                end
            end

            // Data for the read issued last edge is on cdata_rd now.
            if (outstanding) begin
                if (cap_idx != LAST_IDX) begin
                    cap_idx <= cap_idx + 1'b1;
                end
                if (cdata_rd > run_max) begin
                    run_max <= cdata_rd;
                    run_idx <= cap_idx;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_FETCH;
                        busy    <= 1'b1;
                        csel    <= CSEL_L1;
                        cap_idx <= '0;
                        run_max <= '0;
                        run_idx <= '0;
                    end
                end
                ST_FETCH: begin
                    if (issue && rd_idx == LAST_IDX) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // The last word is the last one pushed, so popping it empties the FIFO.
                    if (fifo_pop && o_last && !outstanding) begin
                        state   <= ST_DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        csel    <= '0;
                        max_val <= run_max;
                        max_idx <= run_idx;
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    rd_idx  <= '0;
                    cap_idx <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_l1_stream_out.sv
// Bench for l1_stream_out: memory image model, expected-word queue and
// per-cycle checks of stream, read port and end-of-frame report.
module tb_l1_stream_out;
    localparam int NW = 1024;

    logic        clk;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        crd;
    logic [11:0] caddr_rd;
    logic [2:0]  csel;
    logic [19:0] cdata_rd;
    logic        o_valid;
    logic        o_ready;
    logic [19:0] o_data;
    logic        o_last;
    logic [19:0] max_val;
    logic [9:0]  max_idx;

    l1_stream_out dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .crd      (crd),
        .caddr_rd (caddr_rd),
        .csel     (csel),
        .cdata_rd (cdata_rd),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o_data   (o_data),
        .o_last   (o_last),
        .max_val  (max_val),
        .max_idx  (max_idx)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // memory: data for an address issued at one edge is present the next cycle
    logic [19:0] mem_img [NW];
    always_comb begin
        cdata_rd = 20'hA5A5A;
        if (crd) cdata_rd = mem_img[caddr_rd[9:0]];
    end

    // scoreboard state
    logic [20:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          iss_n = 0;
    int          xfer_n = 0;
    logic        chk_en = 1'b0;
    logic        done_pending = 1'b0;
    logic        frame_done = 1'b0;
    logic        stall_prev = 1'b0;
    logic [19:0] stall_data = '0;
    logic [19:0] model_max = '0;
    logic [9:0]  model_idx = '0;
    int          ready_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // expected stream is the image in raster order; argmax is first occurrence of the maximum
    task automatic model_start();
        exp_q.delete();
        model_max = '0;
        model_idx = '0;
        for (int i = 0; i < NW; i++) begin
            exp_q.push_back({(i == NW - 1), mem_img[i]});
            if (mem_img[i] > model_max) begin
                model_max = mem_img[i];
                model_idx = 10'(i);
            end
        end
        iss_n = 0;
        xfer_n = 0;
        done_pending = 1'b0;
        frame_done = 1'b0;
        stall_prev = 1'b0;
        chk_en = 1'b1;
    endtask

    // compare process
    always @(negedge clk) begin
        if (chk_en) begin
            logic [20:0] e;
            if (crd) begin
                chk("rd_addr", {20'h0, caddr_rd}, iss_n);
                chk("rd_in_range", (iss_n < NW), 1);
                chk("rd_csel", {29'h0, csel}, 32'h3);
                iss_n++;
            end
            chk("inflight_le_depth", ((iss_n - xfer_n) <= 4), 1);
            if (stall_prev) begin
                chk("stall_valid", {31'h0, o_valid}, 1);
                chk("stall_data", {12'h0, o_data}, {12'h0, stall_data});
            end
            if (done_pending) begin
                chk("done_pulse", {31'h0, done}, 1);
                chk("done_busy", {31'h0, busy}, 0);
                chk("max_val", {12'h0, max_val}, {12'h0, model_max});
                chk("max_idx", {22'h0, max_idx}, {22'h0, model_idx});
                done_pending = 1'b0;
                frame_done = 1'b1;
            end else begin
                chk("done_idle", {31'h0, done}, 0);
            end
            if (o_valid && o_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", {12'h0, o_data}, 32'hFFFFFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("o_data", {12'h0, o_data}, {12'h0, e[19:0]});
                    chk("o_last", {31'h0, o_last}, {31'h0, e[20]});
                    if (e[20]) done_pending = 1'b1;
                end
                xfer_n++;
            end
            stall_prev = o_valid && !o_ready;
            stall_data = o_data;
        end
    end

    // downstream ready driver
    initial begin
        o_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       o_ready = 1'b1;
                1:       o_ready = 1'($urandom_range(0, 1));
                default: o_ready = 1'b0;
            endcase
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_frame(input int budget);
        int c;
        c = 0;
        while (!frame_done && c < budget) begin
            @(negedge clk);
            c++;
        end
        #1;
        chk("frame_finished", {31'h0, frame_done}, 1);
        chk("words_streamed", xfer_n, NW);
        chk("exp_q_drained", exp_q.size(), 0);
    endtask

    task automatic wait_xfers(input int n);
        int c;
        c = 0;
        while (xfer_n < n && c < 4000) begin
            @(posedge clk);
            c++;
        end
        chk("reach_word", (xfer_n >= n), 1);
    endtask

    task automatic check_reset_vals();
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_done", {31'h0, done}, 0);
        chk("rst_crd", {31'h0, crd}, 0);
        chk("rst_caddr", {20'h0, caddr_rd}, 0);
        chk("rst_csel", {29'h0, csel}, 0);
        chk("rst_o_valid", {31'h0, o_valid}, 0);
        chk("rst_o_data", {12'h0, o_data}, 0);
        chk("rst_o_last", {31'h0, o_last}, 0);
        chk("rst_max_val", {12'h0, max_val}, 0);
        chk("rst_max_idx", {22'h0, max_idx}, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < NW; i++) mem_img[i] = 20'(i);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_vals();

        // ramp map, o_ready held high, with first-word latency pinned
        ready_mode = 0;
        model_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("lat_busy", {31'h0, busy}, 1);
        chk("lat_crd", {31'h0, crd}, 1);
        chk("lat_o_valid_early", {31'h0, o_valid}, 0);
        @(negedge clk);
        chk("lat_o_valid", {31'h0, o_valid}, 1);
        chk("lat_o_data", {12'h0, o_data}, 0);
        wait_frame(1200);
        chk("ramp_max_val", {12'h0, max_val}, 1023);
        chk("ramp_max_idx", {22'h0, max_idx}, 1023);

        // random data under 50% backpressure
        for (int i = 0; i < NW; i++) mem_img[i] = 20'($urandom_range(0, 20'h7FFFF));
        ready_mode = 1;
        model_start();
        pulse_start();
        wait_frame(4000);

        // full stall: only DEPTH reads go out, address holds
        for (int i = 0; i < NW; i++) mem_img[i] = 20'(i * 3);
        ready_mode = 2;
        model_start();
        pulse_start();
        repeat (100) @(negedge clk);
        #1;
        chk("stall_reads", iss_n, 4);
        chk("stall_crd", {31'h0, crd}, 0);
        chk("stall_caddr", {20'h0, caddr_rd}, 3);
        chk("stall_full_valid", {31'h0, o_valid}, 1);
        ready_mode = 0;
        wait_frame(1500);

        // ties: first occurrence wins
        for (int i = 0; i < NW; i++) mem_img[i] = 20'(i);
        mem_img[5] = 20'h7FFFF;
        mem_img[900] = 20'h7FFFF;
        model_start();
        pulse_start();
        wait_frame(1200);
        chk("tie_max_val", {12'h0, max_val}, 32'h7FFFF);
        chk("tie_max_idx", {22'h0, max_idx}, 5);

        // stray start mid-frame is ignored
        for (int i = 0; i < NW; i++) mem_img[i] = 20'((i * 37) % 1000);
        model_start();
        pulse_start();
        wait_xfers(300);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_frame(1200);

        // reset mid-frame, then a clean new frame
        ready_mode = 1;
        model_start();
        pulse_start();
        wait_xfers(500);
        #1;
        chk_en = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_vals();
        for (int i = 0; i < NW; i++) mem_img[i] = 20'(1023 - i);
        ready_mode = 0;
        model_start();
        pulse_start();
        wait_frame(1200);
        chk("restart_max_val", {12'h0, max_val}, 1023);
        chk("restart_max_idx", {22'h0, max_idx}, 0);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/l1_stream_out.md
# l1_stream_out

Downstream readout stage for the convolution engine. Once the engine has written the 32x32 max-pooled layer-1 map into shared feature memory, this block reads the map back in raster order through the memory read port. It streams each word out on a valid/ready interface, buffering through a small FIFO so that downstream backpressure never loses data. It also tracks the map maximum and its index, and reports both when the frame ends.

## Interface
Parameters:
- MAP_W, 32, pooled map width in words
- MAP_H, 32, pooled map height in words
- DW, 20, data width (ReLU/max-pool output, unsigned magnitude, bit 19 always 0)
- AW, 12, memory address width
- BASE_ADDR, 0, layer-1 start address
- CSEL_L1, 3'b011, memory bank select for layer 1
- DEPTH, 4, output FIFO depth (power of 2, >=2)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begin one frame readout
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last word is accepted downstream
- crd  out  1  memory read strobe
- caddr_rd  out  AW  memory read address
- csel  out  3  bank select
- cdata_rd  in  DW  memory read data
- o_valid  out  1  stream word valid
- o_ready  in  1  downstream accept
- o_data  out  DW  stream word
- o_last  out  1  marks word index MAP_W*MAP_H-1
- max_val  out  DW  largest word of the last completed frame
- max_idx  out  10  raster index of max_val, 0..MAP_W*MAP_H-1

## Operation
- Reset values: busy=0, done=0, crd=0, caddr_rd=0, csel=0, o_valid=0, o_data=0, o_last=0, max_val=0, max_idx=0. FIFO is emptied and all counters are cleared.
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE -> FETCH on start. FETCH -> DRAIN once read MAP_W*MAP_H-1 has been issued. DRAIN -> DONE once the FIFO is empty, no read is outstanding and the last word has been accepted. DONE -> IDLE unconditionally after one cycle.
- start is ignored in every state other than IDLE.
- Memory protocol: crd, caddr_rd and csel are registered. A read issued at edge k returns cdata_rd during the following cycle, and the block captures it at edge k+1. At most one read is outstanding.
- Read issue rule: issue in FETCH only when (fifo_count + outstanding) < DEPTH.
- Issue cadence: reads issue on consecutive cycles while the issue rule allows.
- Address: caddr_rd = BASE_ADDR + rd_idx, with rd_idx running 0..1023 in raster order (row*MAP_W + col).
- csel = CSEL_L1 while busy and 0 otherwise. crd = 0 on any cycle without an issue.
- Stream: o_data and o_valid come from the FIFO head. A transfer occurs when o_valid && o_ready. o_data must stay stable while o_valid && !o_ready.
- o_last is high exactly with word 1023.
- Argmax runs on captured words. Update only when word > running max (strictly greater), so on ties the first occurrence wins.
- The running max and index are cleared on start. max_val and max_idx are committed when entering DONE and hold until the next commit.

## Timing
- Latency: start at edge 0 -> busy=1 and first crd at edge 1 -> word captured at edge 2 -> o_valid=1 at edge 2.
- Throughput: 1 word/clk when o_ready is held high. With o_ready=1 throughout, a frame takes about 1024+4 cycles from start to done.
- FIFO full: reads stall and the read address holds.
- FIFO simultaneous push and pop: occupancy is unchanged.
- Reset mid-frame: all state returns to reset values at the next edge. There is no partial done and no stale o_valid.
- Reads never exceed address BASE_ADDR+1023. The counter does not wrap in any state.

## Structure
- Shared package: MAP_W, MAP_H, DW, AW, the csel bank encodings (layer-0 = 3'b001, layer-1 = 3'b011) and the FSM state enum.
- Sub-module: l1_fifo, a synchronous DEPTH-entry FIFO with push/pop, full/empty and count. The FIFO has no reset on its storage; pointers and count are reset.
- The top level holds the FSM, read-issue counter, outstanding flag, index counters and argmax registers.

## Test plan
- Ramp map (mem[i]=i) with o_ready=1 -> 1024 words 0..1023 in order. o_last only on word 1023. max_val=1023, max_idx=1023. done 1 cycle after the last transfer.
- Random o_ready (50%) -> same data sequence. (fifo_count + outstanding) is never above 4, and o_data never changes while stalled.
- o_ready=0 for 100 cycles after start -> exactly 4 reads issued, then crd=0 and caddr_rd held. Releasing o_ready resumes with no gap or duplicate.
- Ties: mem[5]=mem[900]=20'h7FFFF, all others smaller -> max_val=20'h7FFFF, max_idx=5.
- A start pulse at word 300 -> ignored, and the frame completes normally.
- reset at word 500, then a new start -> outputs at reset values after reset. The new frame restarts at address BASE_ADDR with the correct argmax.
